seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit seven-segment display.
- Sequences the 2-bit digit select that feeds anode_decoder, and drives the shared segment and decimal-point lines for the selected digit.
- Blanks everything for a guard interval between digits to prevent ghosting.
- Double-buffers the 16-bit display value so updates land only on frame boundaries.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/hex_to_seg.sv | 12 +
 rtl/seg_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the scan FSM state type, the dark-segment pattern and hex glyphs.
package seg_pkg;

    typedef enum logic {
        GUARD,
        DISPLAY
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // A digit is a leading zero when it and every digit to its left
    // are zero; the rightmost digit always shows.
    function automatic logic lz_hidden(
        input logic [15:0] val,
        input logic [1:0]  k
    );
        logic [15:0] upper;
        upper = val >> {k, 2'b00};
        return (k != 2'd0) && (upper == 16'd0);
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
// Ports: nibble (4-bit hex in), seg (7-bit {g..a}, active-low out).
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPHS[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with guard
// blanking between digits and a frame-aligned double-buffered value.
// Ports: clk, reset (async, active-high); value/dp_in/blank_in/load
// update path; lz_en live leading-zero suppression; digit_sel,
// digit_on, seg, dp display drive; frame_done and pending status.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000,
    parameter int GUARD_CYCLES   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lz_en,
    input  logic        load,
    output logic [1:0]  digit_sel,
    output logic        digit_on,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        pending
);

    localparam int MAXC = (REFRESH_CYCLES > GUARD_CYCLES) ?
                          REFRESH_CYCLES : GUARD_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);

    scan_state_t   state;
    scan_state_t   state_nx;
    logic [CW-1:0] cnt;
    logic          last;
    logic          start;
    logic          stop;

    logic [15:0] act_val;
    logic [3:0]  act_dp;
    logic [3:0]  act_blank;
    logic [15:0] pnd_val;
    logic [3:0]  pnd_dp;
    logic [3:0]  pnd_blank;

    logic        commit;
    logic [1:0]  sel_nx;
    logic [15:0] src_val;
    logic [3:0]  src_dp;
    logic [3:0]  src_blank;
    logic [3:0]  nibble;
    logic [6:0]  glyph;

    logic [1:0]  sel_d;
    logic        on_d;
    logic [6:0]  seg_d;
    logic        dp_d;
    logic        fd_d;

    assign last = (state == GUARD) ? (cnt == G_LAST)
                                   : (cnt == R_LAST);
    assign start = (state == GUARD) && last;
    assign stop  = (state == DISPLAY) && last;
    assign sel_nx = digit_sel + 2'd1;

    // The frame begins when digit 0 is selected; a waiting update is
    // rendered on that same edge, so it feeds the glyph path directly.
    assign commit = start && (sel_nx == 2'd0) && pending;
    assign src_val   = commit ? pnd_val   : act_val;
    assign src_dp    = commit ? pnd_dp    : act_dp;
    assign src_blank = commit ? pnd_blank : act_blank;
    assign nibble    = src_val[{sel_nx, 2'b00} +: 4];

    hex_to_seg u_glyph (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= GUARD;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            GUARD:   if (last) state_nx = DISPLAY;
            DISPLAY: if (last) state_nx = GUARD;
            default: state_nx = GUARD;
        endcase
    end

    always_comb begin
        sel_d = digit_sel;
        on_d  = digit_on;
        seg_d = seg;
        dp_d  = dp;
        fd_d  = 1'b0;
        if (start) begin
            sel_d = sel_nx;
            on_d  = 1'b1;
            if (src_blank[sel_nx] ||
                (lz_en && lz_hidden(src_val, sel_nx)))
                seg_d = SEG_OFF;
            else
                seg_d = glyph;
            dp_d = src_blank[sel_nx] ? 1'b1 : ~src_dp[sel_nx];
        end else if (stop) begin
            on_d  = 1'b0;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
            fd_d  = (digit_sel == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_sel  <= 2'd3;
            digit_on   <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            digit_sel  <= sel_d;
            digit_on   <= on_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= fd_d;
        end
    end

    // A load coinciding with a commit becomes the next frame's update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_val   <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            pnd_val   <= '0;
            pnd_dp    <= '0;
            pnd_blank <= '0;
            pending   <= 1'b0;
        end else begin
            if (commit) begin
                act_val   <= pnd_val;
                act_dp    <= pnd_dp;
                act_blank <= pnd_blank;
            end
            if (load) begin
                pnd_val   <= value;
                pnd_dp    <= dp_in;
                pnd_blank <= blank_in;
                pending   <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with REFRESH=4, GUARD=2.
// Reference model works from elapsed cycles since reset release.
module tb_seg_scan_ctrl;

    localparam int RC    = 4;
    localparam int GC    = 2;
    localparam int SLOT  = RC + GC;
    localparam int FRAME = 4 * SLOT;

    localparam logic [6:0] GLY [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  digit_sel;
    logic        digit_on;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        pending;

    int compared = 0;
    int mismatched = 0;

    // model state
    int          n;
    logic [15:0] m_aval, m_pval;
    logic [3:0]  m_adp, m_abl, m_pdp, m_pbl;
    logic        m_pend;
    logic [1:0]  e_sel;
    logic        e_on, e_dp, e_fd;
    logic [6:0]  e_seg;

    seg_scan_ctrl #(
        .REFRESH_CYCLES (RC),
        .GUARD_CYCLES   (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .load       (load),
        .digit_sel  (digit_sel),
        .digit_on   (digit_on),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h n=%0d",
                   tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_aval = '0; m_adp = '0; m_abl = '0;
        m_pval = '0; m_pdp = '0; m_pbl = '0;
        m_pend = 1'b0;
        e_sel = 2'd3; e_on = 1'b0; e_seg = 7'h7F;
        e_dp = 1'b1; e_fd = 1'b0;
    endtask

    task automatic check_all();
        chk("digit_sel", 16'(digit_sel), 16'(e_sel));
        chk("digit_on", 16'(digit_on), 16'(e_on));
        chk("seg", 16'(seg), 16'(e_seg));
        chk("dp", 16'(dp), 16'(e_dp));
        chk("frame_done", 16'(frame_done), 16'(e_fd));
        chk("pending", 16'(pending), 16'(m_pend));
    endtask

    task automatic render(input int d, input logic lz);
        logic [3:0]  nib;
        logic [15:0] up;
        logic        supp;
        nib  = m_aval[4*d +: 4];
        up   = m_aval >> (4 * d);
        supp = lz && (d != 0) && (up == 16'd0);
        e_seg = (m_abl[d] || supp) ? 7'h7F : GLY[nib];
        e_dp  = m_abl[d] ? 1'b1 : ~m_adp[d];
    endtask

    task automatic tick();
        logic        ld, lz;
        logic [15:0] v;
        logic [3:0]  dv, bv;
        int          m, w, d;
        ld = load; lz = lz_en; v = value;
        dv = dp_in; bv = blank_in;
        @(posedge clk);
        n++;
        e_fd = 1'b0;
        if (n >= GC) begin
            m = n - GC;
            w = m % SLOT;
            d = (m / SLOT) % 4;
            if ((m % FRAME == 0) && m_pend) begin
                m_aval = m_pval;
                m_adp  = m_pdp;
                m_abl  = m_pbl;
                m_pend = 1'b0;
            end
            if (w == 0) begin
                e_sel = 2'(d);
                e_on  = 1'b1;
                render(d, lz);
            end
            if (w == RC) begin
                e_on  = 1'b0;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end
            e_fd = (m % FRAME == 3 * SLOT + RC);
        end
        if (ld) begin
            m_pval = v; m_pdp = dv; m_pbl = bv;
            m_pend = 1'b1;
        end
        #1;
        check_all();
        load = 1'b0;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] v,
                           input logic [3:0] dv,
                           input logic [3:0] bv);
        value = v; dp_in = dv; blank_in = bv;
        load = 1'b1;
    endtask

    // advance so the next edge is the frame-start (commit) edge
    task automatic to_commit_edge();
        for (int i = 0; i < FRAME + 2; i++) begin
            if (n + 1 >= GC && (n + 1 - GC) % FRAME == 0) break;
            tick();
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // load lands after the first commit: frame 1 shows 0000
        ticks(GC + 1);
        do_load(16'h1234, 4'b0000, 4'b0000);
        ticks(2 * FRAME + 4);

        // leading-zero suppression on, then off
        do_load(16'h00A0, 4'b0000, 4'b0000);
        lz_en = 1'b1;
        ticks(2 * FRAME);
        lz_en = 1'b0;
        ticks(FRAME);

        // blanking and decimal points
        do_load(16'h8888, 4'b0001, 4'b0100);
        ticks(2 * FRAME);

        // last load within a frame wins
        to_commit_edge();
        tick();
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        ticks(3);
        do_load(16'hFFFF, 4'b0000, 4'b0000);
        ticks(2 * FRAME);

        // load on the commit edge defers to the next frame
        do_load(16'h1111, 4'b0000, 4'b0000);
        tick();
        to_commit_edge();
        do_load(16'h5555, 4'b0000, 4'b0000);
        tick();
        chk("commit_pending", 16'(pending), 16'd1);
        chk("commit_seg", 16'(seg), 16'h79);
        ticks(2 * FRAME);

        // randomized traffic
        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 9) == 0)
                do_load(16'($urandom), 4'($urandom),
                        4'($urandom_range(0, 3) == 0 ?
                           $urandom : 0));
            if ($urandom_range(0, 29) == 0)
                lz_en = 1'($urandom);
            tick();
        end

        // reset in the middle of digit 2's display
        do_load(16'h4321, 4'b1111, 4'b0000);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (e_sel == 2'd2 && e_on) break;
            tick();
        end
        chk("reached_digit2", 16'(e_sel), 16'd2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        ticks(GC);
        chk("post_reset_on", 16'(digit_on), 16'd1);
        chk("post_reset_seg", 16'(seg), 16'h40);
        ticks(FRAME + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
